// File: rtl/run_pkg.sv
// Shared types and defaults for the run sequencer.
package run_pkg;

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} run_st_t;

    localparam int unsigned DONE_PC_DEF = 128;

endpackage

// File: rtl/mem_port_mux.sv
// Combinational data-memory port select between host and core.
module mem_port_mux #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          host_gnt,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_din,
    output logic [DW-1:0] core_dout,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_din,
    output logic [DW-1:0] host_dout,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    always_comb begin
        mem_we   = core_we;
        mem_addr = core_addr;
        mem_din  = core_din;
        if (host_gnt) begin
            mem_we   = host_we;
            mem_addr = host_addr;
            mem_din  = host_din;
        end
    end

    // Read data is broadcast; each side only trusts it while it owns the port.
    assign core_dout = mem_dout;
    assign host_dout = mem_dout;

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: holds the core in reset while the host owns dat_mem, runs the program,
// and detects completion (PC reaches DONE_PC) or a watchdog timeout.
module run_ctrl
    import run_pkg::*;
#(
    parameter int unsigned D       = 12,
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned DONE_PC = DONE_PC_DEF,
    parameter int unsigned CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cyc_cnt,
    output logic          core_rst,
    input  logic [D-1:0]  prog_ctr,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_din,
    output logic [DW-1:0] core_dout,
    output logic          host_gnt,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_din,
    output logic [DW-1:0] host_dout,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [D-1:0]  DonePc  = D'(DONE_PC);
    localparam logic [CW-1:0] CntMax  = '1;

    run_st_t       state_q;
    logic          done_q;
    logic          timeout_q;
    logic [CW-1:0] cnt_q;
    logic          core_rst_q;
    logic          host_gnt_q;

    // Outputs are registered alongside the state so they reflect the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            core_rst_q <= 1'b1;
            host_gnt_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q    <= START;
                        host_gnt_q <= 1'b0;
                        cnt_q      <= '0;
                        timeout_q  <= 1'b0;
                    end
                end
                START: begin
                    state_q    <= RUN;
                    core_rst_q <= 1'b0;
                end
                RUN: begin
                    if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    // Completion takes priority over the watchdog in the same cycle.
                    if (prog_ctr == DonePc) begin
                        state_q    <= DONE;
                        timeout_q  <= 1'b0;
                        done_q     <= 1'b1;
                        core_rst_q <= 1'b1;
                        host_gnt_q <= 1'b1;
                    end else if (cnt_q == CntMax) begin
                        state_q    <= DONE;
                        timeout_q  <= 1'b1;
                        done_q     <= 1'b1;
                        core_rst_q <= 1'b1;
                        host_gnt_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!req) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    core_rst_q <= 1'b1;
                    host_gnt_q <= 1'b1;
                end
            endcase
        end
    end

    assign done     = done_q;
    assign timeout  = timeout_q;
    assign cyc_cnt  = cnt_q;
    assign core_rst = core_rst_q;
    assign host_gnt = host_gnt_q;

    mem_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .host_gnt  (host_gnt_q),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_din  (core_din),
        .core_dout (core_dout),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_din  (host_din),
        .host_dout (host_dout),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: default instance with a memory model, plus a CW=4 watchdog instance.
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        done;
    logic        timeout;
    logic [15:0] cyc_cnt;
    logic        core_rst;
    logic [11:0] prog_ctr;
    logic        core_we;
    logic [7:0]  core_addr;
    logic [7:0]  core_din;
    logic [7:0]  core_dout;
    logic        host_gnt;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [7:0]  host_din;
    logic [7:0]  host_dout;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;

    logic        w_req;
    logic        w_done;
    logic        w_timeout;
    logic [3:0]  w_cyc_cnt;
    logic        w_core_rst;
    logic [11:0] w_pc;
    logic [7:0]  w_core_dout;
    logic        w_host_gnt;
    logic [7:0]  w_host_dout;
    logic        w_mem_we;
    logic [7:0]  w_mem_addr;
    logic [7:0]  w_mem_din;
    logic [7:0]  w_mem_dout;
    logic        zero1;
    logic [7:0]  zero8;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
    assign mem_dout = mem[mem_addr];

    run_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .timeout   (timeout),
        .cyc_cnt   (cyc_cnt),
        .core_rst  (core_rst),
        .prog_ctr  (prog_ctr),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_din  (core_din),
        .core_dout (core_dout),
        .host_gnt  (host_gnt),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_din  (host_din),
        .host_dout (host_dout),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    run_ctrl #(.CW(4)) u_wdt (
        .clk       (clk),
        .reset     (reset),
        .req       (w_req),
        .done      (w_done),
        .timeout   (w_timeout),
        .cyc_cnt   (w_cyc_cnt),
        .core_rst  (w_core_rst),
        .prog_ctr  (w_pc),
        .core_we   (zero1),
        .core_addr (zero8),
        .core_din  (zero8),
        .core_dout (w_core_dout),
        .host_gnt  (w_host_gnt),
        .host_we   (zero1),
        .host_addr (zero8),
        .host_din  (zero8),
        .host_dout (w_host_dout),
        .mem_we    (w_mem_we),
        .mem_addr  (w_mem_addr),
        .mem_din   (w_mem_din),
        .mem_dout  (w_mem_dout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; prog_ctr = '0;
        core_we = 1'b0; core_addr = '0; core_din = '0;
        host_we = 1'b0; host_addr = '0; host_din = '0;
        w_req = 1'b0; w_pc = '0; w_mem_dout = '0; zero1 = 1'b0; zero8 = '0;
        step(); step();
        check("rst_done",     {31'b0, done},     32'd0);
        check("rst_timeout",  {31'b0, timeout},  32'd0);
        check("rst_cnt",      {16'b0, cyc_cnt},  32'd0);
        check("rst_core_rst", {31'b0, core_rst}, 32'd1);
        check("rst_host_gnt", {31'b0, host_gnt}, 32'd1);
        reset = 1'b1;
        step();

        // Reset mid-run at cyc_cnt=37; req drop during run is ignored
        req = 1'b1; step();
        req = 1'b0; step();
        repeat (37) step();
        check("t1_cnt37",    {16'b0, cyc_cnt},  32'd37);
        check("t1_core_run", {31'b0, core_rst}, 32'd0);
        reset = 1'b0; #1;
        check("t1_gnt",      {31'b0, host_gnt}, 32'd1);
        check("t1_core_rst", {31'b0, core_rst}, 32'd1);
        check("t1_done",     {31'b0, done},     32'd0);
        check("t1_cnt",      {16'b0, cyc_cnt},  32'd0);
        step(); reset = 1'b1; step();

        // Host preload, then req in the same cycle as a host write
        host_we = 1'b1; host_addr = 8'h10; host_din = 8'h11; step();
        host_addr = 8'h05; host_din = 8'hA3; req = 1'b1; #1;
        check("t2_gnt_idle", {31'b0, host_gnt}, 32'd1);
        check("t2_we_idle",  {31'b0, mem_we},   32'd1);
        step();
        host_we = 1'b0; req = 1'b0; #1;
        check("t2_start_core_rst", {31'b0, core_rst}, 32'd1);
        check("t2_start_gnt",      {31'b0, host_gnt}, 32'd0);
        check("t2_start_cnt",      {16'b0, cyc_cnt},  32'd0);
        step();
        check("t2_run_core_rst", {31'b0, core_rst}, 32'd0);

        // Host write attempts during RUN must not reach memory
        host_we = 1'b1; host_addr = 8'h10; host_din = 8'hFF;
        core_we = 1'b0; core_addr = 8'h20; core_din = 8'h5A; #1;
        check("t3_we_blocked", {31'b0, mem_we},  32'd0);
        check("t3_addr_core",  {24'b0, mem_addr}, 32'h20);
        core_we = 1'b1; #1;
        check("t3_we_core",  {31'b0, mem_we},  32'd1);
        check("t3_din_core", {24'b0, mem_din}, 32'h5A);
        step();
        core_we = 1'b0;
        repeat (197) step();
        host_we = 1'b0;
        step();
        check("t2_cnt199", {16'b0, cyc_cnt}, 32'd199);
        prog_ctr = 12'd128; step();
        prog_ctr = 12'd0;
        check("t2_done",    {31'b0, done},     32'd1);
        check("t2_timeout", {31'b0, timeout},  32'd0);
        check("t2_cnt",     {16'b0, cyc_cnt},  32'd200);
        check("t2_gnt",     {31'b0, host_gnt}, 32'd1);
        check("t2_core_rst",{31'b0, core_rst}, 32'd1);
        host_addr = 8'h05; #1;
        check("t2_read05", {24'b0, host_dout}, 32'hA3);
        host_addr = 8'h10; #1;
        check("t3_read10", {24'b0, host_dout}, 32'h11);
        host_addr = 8'h20; #1;
        check("t3_read20", {24'b0, host_dout}, 32'h5A);

        // req held high after done must not restart
        req = 1'b1;
        repeat (50) step();
        check("t6_hold_done", {31'b0, done},     32'd1);
        check("t6_hold_gnt",  {31'b0, host_gnt}, 32'd1);
        check("t6_hold_cnt",  {16'b0, cyc_cnt},  32'd200);
        req = 1'b0; step();
        check("t6_idle_done", {31'b0, done},     32'd0);
        check("t6_idle_gnt",  {31'b0, host_gnt}, 32'd1);
        check("t6_idle_cnt",  {16'b0, cyc_cnt},  32'd200);
        req = 1'b1; step();
        check("t6_start_core_rst", {31'b0, core_rst}, 32'd1);
        check("t6_start_gnt",      {31'b0, host_gnt}, 32'd0);
        check("t6_start_cnt",      {16'b0, cyc_cnt},  32'd0);
        req = 1'b0; step();
        check("t6_run_core_rst", {31'b0, core_rst}, 32'd0);
        prog_ctr = 12'd128; step();
        prog_ctr = 12'd0;
        check("t6_done2", {31'b0, done},    32'd1);
        check("t6_cnt1",  {16'b0, cyc_cnt}, 32'd1);
        step();

        // Watchdog with CW=4
        w_req = 1'b1; step();
        w_req = 1'b0; step();
        repeat (15) step();
        check("t4_pre_done", {31'b0, w_done},   32'd0);
        check("t4_pre_cnt",  {28'b0, w_cyc_cnt}, 32'hF);
        step();
        check("t4_done",    {31'b0, w_done},    32'd1);
        check("t4_timeout", {31'b0, w_timeout}, 32'd1);
        check("t4_cnt",     {28'b0, w_cyc_cnt}, 32'hF);
        step();

        // Completion and watchdog in the same cycle
        w_req = 1'b1; step();
        check("t5_start_timeout", {31'b0, w_timeout}, 32'd0);
        w_req = 1'b0; step();
        repeat (15) step();
        w_pc = 12'd128; step();
        w_pc = 12'd0;
        check("t5_done",    {31'b0, w_done},    32'd1);
        check("t5_timeout", {31'b0, w_timeout}, 32'd0);
        check("t5_cnt",     {28'b0, w_cyc_cnt}, 32'hF);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
